// File: rtl/rr_hold_arbiter_pkg.sv
// Shared types and default sizing for the round-robin hold arbiter.
package rr_hold_arbiter_pkg;

  // Arbiter FSM: IDLE arbitrates, BUSY holds a grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Default build: four requesters, eight-cycle hold limit.
  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Owner-index width and hold-counter width for the default build.
  localparam int IDW  = $clog2(N_DEF);
  localparam int CNTW = $clog2(MAX_HOLD_DEF + 1);

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin winner search: first set req bit at or after ptr,
// wrapping modulo N. The request vector is doubled so the wrap becomes a plain
// LSB-first priority scan over the bits at or above ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner_idx,
  output logic [N-1:0]  winner_onehot
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic           found;

  // Masked double-width priority encode; the upper copy covers the wrap.
  always_comb begin
    dbl           = {req, req};
    mask          = {(2*N){1'b1}} << ptr;
    masked        = dbl & mask;
    any           = |req;
    found         = 1'b0;
    winner_idx    = '0;
    winner_onehot = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        if (i >= N) winner_idx = IW'(i - N);
        else        winner_idx = IW'(i);
      end
    end
    if (any) winner_onehot = N'(1) << winner_idx;
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with hold-time preemption and owner lock.
// Handshake: req is a level; a requester owns the resource while its gnt bit
// is high and keeps it as long as req stays high, subject to the hold limit.
// Every change of owner passes through exactly one all-zero grant cycle.
module rr_hold_arbiter
  import rr_hold_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 lock,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 preempt,
  output state_e               dbg_state
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  state_e        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] gnt_id_n;
  logic          preempt_n;

  logic          any;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic          others;
  logic [IW-1:0] nxt_ptr;
  logic          at_limit;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req           (req),
    .ptr           (ptr),
    .any           (any),
    .winner_idx    (win_idx),
    .winner_onehot (win_oh)
  );

  // State, pointer, counter and output registers; reset works mid-grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      preempt <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gnt     <= gnt_n;
      gnt_id  <= gnt_id_n;
      preempt <= preempt_n;
    end
  end

  // Next-state logic: release beats preemption beats holding.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    preempt_n = 1'b0;
    others    = |(req & ~gnt);
    at_limit  = (cnt == CW'(MAX_HOLD));
    nxt_ptr   = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);
    case (state)
      IDLE: begin
        if (any) begin
          state_n  = BUSY;
          gnt_n    = win_oh;
          gnt_id_n = win_idx;
          cnt_n    = CW'(1);
        end
      end
      BUSY: begin
        if (!req[gnt_id] || (at_limit && others && !lock)) begin
          // Voluntary release or forced preemption; next search starts past the owner.
          state_n   = IDLE;
          gnt_n     = '0;
          gnt_id_n  = '0;
          cnt_n     = '0;
          ptr_n     = nxt_ptr;
          preempt_n = req[gnt_id];
        end else if (!at_limit) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state == BUSY);
  assign dbg_state = state;

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Registered round-robin arbiter sharing one resource among N requesters. It is the fair companion to the team's fixed-priority 4-way grant block.
- Ownership is held while the owner keeps its request asserted. A hold-time limit forces preemption when others are waiting, unless the owner asserts lock.
- Sits in front of a shared bus or engine. Exactly one grant at a time, with one idle cycle between owners.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum grant cycles before preemption is allowed (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request level.
- lock  input  1  owner asks to suppress preemption; ignored when no grant is active.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  $clog2(N)  index of the current owner; 0 when idle.
- busy  output  1  high while gnt is non-zero.
- preempt  output  1  one-cycle pulse, coincident with the zero-grant cycle that follows a forced release.

Behaviour:
- Reset is asynchronous and active-low, and is honoured mid-grant. Reset values:
  - gnt=0, gnt_id=0, busy=0, preempt=0.
  - state=IDLE, ptr=0, cnt=0.
- Internal state:
  - ptr is the round-robin start index.
  - cnt is the hold counter, $clog2(MAX_HOLD+1) bits wide.
- Winner search: starting at ptr, scan ptr, ptr+1, ..., wrapping modulo N. The first set req bit wins.
- IDLE:
  - If req==0, stay in IDLE; gnt stays 0.
  - Else at the clock edge: gnt = one-hot(winner), gnt_id = winner, cnt = 1, go to BUSY.
  - Latency: req sampled at edge t gives gnt visible after edge t (one cycle).
- BUSY (owner k = gnt_id), priority order of evaluation at each edge:
  1. Release: req[k]==0. Set gnt=0, ptr=(k+1)%N, go to IDLE, preempt=0. lock is ignored.
  2. Preempt: cnt==MAX_HOLD, another req bit is set, and lock==0. Set gnt=0, ptr=(k+1)%N, preempt=1 for the next cycle, go to IDLE.
  3. Otherwise keep the grant. cnt increments and saturates at MAX_HOLD.
  - Lock dropping while cnt is saturated and others are waiting preempts at the next edge.
- Consequence of the transitions: every ownership change passes through exactly one gnt=0 cycle. IDLE arbitrates in that cycle, so the next owner appears on the following edge.
- A sole requester keeps its grant indefinitely: cnt saturates and preempt never pulses.
- preempt is registered. It is 0 in every cycle except the single cycle after a forced release.
- The arbiter never drives two grant bits. gnt is never non-zero while state is IDLE.
- Requests that appear and vanish between edges are not seen; arbitration is level-sampled.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY};
  - localparams IDW = $clog2(N) and CNTW = $clog2(MAX_HOLD+1).
- One combinational sub-module, rr_pick, parameterised by N:
  - inputs req and ptr; outputs any, winner_idx, winner_onehot;
  - implemented as a double-width masked priority encoder.
- The top holds the FSM, ptr, cnt and the output registers.

Test Plan:
1. Assert reset low mid-grant (gnt=0010). Required: gnt=0000, gnt_id=0, busy=0 immediately (asynchronous). After release with req=1000: gnt=1000 one edge later.
2. After reset, req=1111 held, lock=0, MAX_HOLD=8. Required sequence:
   - gnt=0001 for 8 cycles, then 0000 with preempt=1;
   - then 0010 for 8 cycles, then 0100, then 1000, then 0001;
   - each owner change separated by one 0000 cycle.
3. req=0100 steady for 30 cycles. Required: gnt=0100 for all 30, no preempt, busy=1, gnt_id=2.
4. Owner 1 granted, req=1111, lock=1 held until cycle 12 of the grant. Required: gnt=0010 for 12 cycles with no preempt. Lock drops, then at the next edge gnt=0000 and preempt=1; the following owner is 0100.
5. gnt=0100; req[2] drops after 3 grant cycles while req=0001. Required: gnt=0100 for 3 cycles, 0000 for 1 cycle with preempt=0, then 0001 (ptr=3 scans 3, then 0).
6. IDLE; req goes 0000 to 1010 with ptr=0. Required: gnt=0010 next edge, gnt_id=1. Release gives ptr=2, so the next winner is 1000.
